// File: rtl/avl_bridge_pkg.sv
// Shared types and constants for the CPU-to-Avalon word bridge.
package avl_bridge_pkg;

  localparam int unsigned AVL_ADDR_W_DEF = 26;
  localparam int unsigned AVL_DATA_W_DEF = 128;
  localparam int unsigned CPU_ADDR_W_DEF = 32;
  localparam int unsigned CPU_DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/avl_line_buf.sv
// One-entry read line buffer: tag/valid compare, fill and byte-masked write-through.
module avl_line_buf
  import avl_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = AVL_ADDR_W_DEF,
  parameter int unsigned DATA_W = AVL_DATA_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [ADDR_W-1:0]   lookup_addr_i,
  output logic                hit_o,
  output logic [DATA_W-1:0]   line_o,
  input  logic                fill_en_i,
  input  logic [ADDR_W-1:0]   fill_addr_i,
  input  logic [DATA_W-1:0]   fill_data_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign hit_o  = valid_q && (tag_q == lookup_addr_i);
  assign line_o = data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en_i) begin
      valid_d = 1'b1;
      tag_d   = fill_addr_i;
      data_d  = fill_data_i;
    end else if (wr_en_i && valid_q && (tag_q == wr_addr_i)) begin
      for (int unsigned b = 0; b < DATA_W / 8; b++)
        if (wr_be_i[b]) data_d[b*8 +: 8] = wr_data_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/avl_word_bridge.sv
// CPU word request to single line-wide Avalon-MM transaction bridge.
// Optional one-entry read line buffer enabled by AVL_BRIDGE_LINE_BUF_EN.
module avl_word_bridge
  import avl_bridge_pkg::*;
#(
  parameter int unsigned AVL_ADDR_W = AVL_ADDR_W_DEF,
  parameter int unsigned AVL_DATA_W = AVL_DATA_W_DEF,
  parameter int unsigned CPU_ADDR_W = CPU_ADDR_W_DEF,
  parameter int unsigned CPU_DATA_W = CPU_DATA_W_DEF
) (
  input  logic                    iCLK,
  input  logic                    iRST_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [CPU_ADDR_W-1:0]   cpu_addr,
  input  logic [CPU_DATA_W-1:0]   cpu_wdata,
  input  logic [CPU_DATA_W/8-1:0] cpu_be,
  output logic                    cpu_ready,
  output logic                    cpu_wdone,
  output logic                    cpu_rvalid,
  output logic [CPU_DATA_W-1:0]   cpu_rdata,
  output logic                    cpu_err,
  input  logic                    avl_waitrequest,
  input  logic                    avl_readdatavalid,
  input  logic [AVL_DATA_W-1:0]   avl_readdata,
  output logic [AVL_ADDR_W-1:0]   avl_address,
  output logic                    avl_read,
  output logic                    avl_write,
  output logic [AVL_DATA_W-1:0]   avl_writedata,
  output logic [AVL_DATA_W/8-1:0] avl_byteenable
);

  localparam int unsigned LB       = clog2(AVL_DATA_W / 8);
  localparam int unsigned WB       = clog2(CPU_DATA_W / 8);
  localparam int unsigned NW       = AVL_DATA_W / CPU_DATA_W;
  localparam int unsigned IDX_W    = (NW > 1) ? clog2(NW) : 1;
  localparam int unsigned CPU_BE_W = CPU_DATA_W / 8;
  localparam int unsigned AVL_BE_W = AVL_DATA_W / 8;

  state_e                  state_q, state_d;
  logic [AVL_ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CPU_DATA_W-1:0]   wdata_q, wdata_d;
  logic [CPU_BE_W-1:0]     be_q, be_d;
  logic [CPU_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    wdone_q, wdone_d;
  logic                    err_q, err_d;
  logic                    hit_q, hit_d;

  logic [AVL_ADDR_W-1:0]   line_addr;
  logic [IDX_W-1:0]        word_idx;
  logic                    misalign;
  logic                    lb_hit;
  logic [AVL_DATA_W-1:0]   lb_line;
  logic [AVL_BE_W-1:0]     be_line;
  logic                    unused_addr;

  assign line_addr   = cpu_addr[LB +: AVL_ADDR_W];
  assign unused_addr = ^cpu_addr;

  if (NW > 1) begin : g_idx
    assign word_idx = cpu_addr[WB +: IDX_W];
  end else begin : g_no_idx
    assign word_idx = '0;
  end

  if (WB > 0) begin : g_align
    assign misalign = |cpu_addr[WB-1:0];
  end else begin : g_no_align
    assign misalign = 1'b0;
  end

  function automatic logic [CPU_DATA_W-1:0] sel_word(input logic [AVL_DATA_W-1:0] ln,
                                                      input logic [IDX_W-1:0] idx);
    logic [CPU_DATA_W-1:0] w_sel;
    w_sel = '0;
    for (int unsigned w = 0; w < NW; w++)
      if (idx == IDX_W'(w)) w_sel = ln[w*CPU_DATA_W +: CPU_DATA_W];
    return w_sel;
  endfunction

  always_comb begin
    be_line = '0;
    for (int unsigned w = 0; w < NW; w++)
      if (idx_q == IDX_W'(w)) be_line[w*CPU_BE_W +: CPU_BE_W] = be_q;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    wdone_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (misalign) begin
            err_d = 1'b1;
          end else begin
            addr_d  = line_addr;
            idx_d   = word_idx;
            wdata_d = cpu_wdata;
            be_d    = cpu_be;
            hit_d   = !cpu_we && lb_hit;
            // A buffer hit skips the Avalon request and resolves in RD_WAIT.
            if (cpu_we)      state_d = ST_WR;
            else if (lb_hit) state_d = ST_RD_WAIT;
            else             state_d = ST_RD_REQ;
          end
        end
      end
      ST_WR: begin
        if (!avl_waitrequest) begin
          wdone_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (!avl_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (hit_q) begin
          rdata_d = sel_word(lb_line, idx_q);
          state_d = ST_RESP;
        end else if (avl_readdatavalid) begin
          rdata_d = sel_word(avl_readdata, idx_q);
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      wdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      wdone_q <= wdone_d;
      err_q   <= err_d;
    end
  end

`ifdef AVL_BRIDGE_LINE_BUF_EN
  avl_line_buf #(
    .ADDR_W (AVL_ADDR_W),
    .DATA_W (AVL_DATA_W)
  ) u_line_buf (
    .clk_i         (iCLK),
    .rst_n_i       (iRST_n),
    .lookup_addr_i (line_addr),
    .hit_o         (lb_hit),
    .line_o        (lb_line),
    .fill_en_i     ((state_q == ST_RD_WAIT) && !hit_q && avl_readdatavalid),
    .fill_addr_i   (addr_q),
    .fill_data_i   (avl_readdata),
    .wr_en_i       ((state_q == ST_WR) && !avl_waitrequest),
    .wr_addr_i     (addr_q),
    .wr_data_i     (avl_writedata),
    .wr_be_i       (be_line)
  );
`else
  assign lb_hit  = 1'b0;
  assign lb_line = '0;
`endif

  assign cpu_ready      = (state_q == ST_IDLE);
  assign cpu_rvalid     = (state_q == ST_RESP);
  assign cpu_wdone      = wdone_q;
  assign cpu_err        = err_q;
  assign cpu_rdata      = rdata_q;
  assign avl_address    = addr_q;
  assign avl_read       = (state_q == ST_RD_REQ);
  assign avl_write      = (state_q == ST_WR);
  assign avl_writedata  = {NW{wdata_q}};
  assign avl_byteenable = be_line;

endmodule

// File: tb/tb_avl_word_bridge.sv
// Directed bench for avl_word_bridge with a byte-level CPU memory model and an Avalon slave model.
module tb_avl_word_bridge;

  logic         iCLK = 1'b0;
  logic         iRST_n = 1'b0;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [3:0]   cpu_be;
  logic         cpu_ready, cpu_wdone, cpu_rvalid, cpu_err;
  logic [31:0]  cpu_rdata;
  logic         avl_waitrequest, avl_readdatavalid;
  logic [127:0] avl_readdata;
  logic [25:0]  avl_address;
  logic         avl_read, avl_write;
  logic [127:0] avl_writedata;
  logic [15:0]  avl_byteenable;

  always #5 iCLK = ~iCLK;

  avl_word_bridge #(
    .AVL_ADDR_W (26),
    .AVL_DATA_W (128),
    .CPU_ADDR_W (32),
    .CPU_DATA_W (32)
  ) dut (
    .iCLK              (iCLK),
    .iRST_n            (iRST_n),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_be            (cpu_be),
    .cpu_ready         (cpu_ready),
    .cpu_wdone         (cpu_wdone),
    .cpu_rvalid        (cpu_rvalid),
    .cpu_rdata         (cpu_rdata),
    .cpu_err           (cpu_err),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_readdata      (avl_readdata),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_byteenable    (avl_byteenable)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // CPU-view byte memory (expected values) and Avalon-side line memory (slave).
  logic [7:0]   rmem [0:1023];
  logic [127:0] smem [0:63];

  int wait_n = 0;
  int rdv_delay = 1;
  int stall = 0;
  int rdv_cnt = 0;
  bit in_cmd = 0;
  logic [127:0] rd_line;

  logic [25:0]  exp_wr_line, exp_rd_line;
  logic [15:0]  exp_wr_be;
  logic [127:0] exp_wr_data;
  logic [31:0]  exp_rword;
  bit           exp_err;

  int n_wr_cyc = 0, n_rd_cyc = 0, n_rvalid = 0, n_wdone = 0, n_err = 0;
  logic [25:0] last_wr_addr, last_rd_addr;
  logic [15:0] last_wr_be;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slave_loop();
    forever begin
      @(negedge iCLK);
      avl_readdatavalid = 1'b0;
      if (rdv_cnt > 0) begin
        rdv_cnt--;
        if (rdv_cnt == 0) begin
          avl_readdatavalid = 1'b1;
          avl_readdata      = rd_line;
        end
      end
      if (!iRST_n) begin
        in_cmd = 0;
        avl_waitrequest = 1'b0;
      end else if (avl_read || avl_write) begin
        if (!in_cmd) begin
          in_cmd = 1;
          stall  = wait_n;
        end
        if (stall > 0) begin
          avl_waitrequest = 1'b1;
          stall--;
        end else begin
          avl_waitrequest = 1'b0;
          in_cmd = 0;
          if (avl_write) begin
            for (int b = 0; b < 16; b++)
              if (avl_byteenable[b]) smem[avl_address[5:0]][b*8 +: 8] = avl_writedata[b*8 +: 8];
          end else begin
            rd_line = smem[avl_address[5:0]];
            rdv_cnt = rdv_delay;
          end
        end
      end else begin
        avl_waitrequest = 1'b0;
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge iCLK);
      if (iRST_n) begin
        if (avl_read || avl_write) chk("ready_low_while_busy", cpu_ready, 1'b0);
        if (avl_write) begin
          n_wr_cyc++;
          last_wr_addr = avl_address;
          last_wr_be   = avl_byteenable;
          chk("wr_addr", avl_address, exp_wr_line);
          chk("wr_be", avl_byteenable, exp_wr_be);
          chk("wr_data", avl_writedata, exp_wr_data);
        end
        if (avl_read) begin
          n_rd_cyc++;
          last_rd_addr = avl_address;
          chk("rd_addr", avl_address, exp_rd_line);
        end
        if (cpu_rvalid) begin
          n_rvalid++;
          chk("rdata", cpu_rdata, exp_rword);
        end
        if (cpu_wdone) n_wdone++;
        if (cpu_err) begin
          n_err++;
          chk("err_expected", 1'b1, exp_err);
        end
      end
    end
  endtask

  task automatic preload_word(input logic [31:0] addr, input logic [31:0] val);
    int a;
    a = int'(addr[9:0]);
    for (int k = 0; k < 4; k++) rmem[a + k] = val[k*8 +: 8];
    smem[addr[9:4]][addr[3:2]*32 +: 32] = val;
  endtask

  // Issues one CPU request and waits for its completion pulse (wdone/rvalid/err).
  // hold=1 keeps cpu_req high after accept and turns it into a read of the same address.
  task automatic cpu_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit hold, output int acc, output int done);
    int n;
    int a;
    a = int'(addr[9:0]);
    exp_err = (addr[1:0] != 2'b00);
    if (we) begin
      exp_wr_line = addr[29:4];
      exp_wr_be   = 16'(be) << (4 * addr[3:2]);
      exp_wr_data = {4{wd}};
      if (!exp_err)
        for (int k = 0; k < 4; k++) if (be[k]) rmem[a + k] = wd[k*8 +: 8];
    end else begin
      exp_rd_line = addr[29:4];
      exp_rword   = {rmem[a + 3], rmem[a + 2], rmem[a + 1], rmem[a]};
    end
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be; cpu_req = 1'b1;
    n = 0;
    while (!cpu_ready && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    if (!cpu_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cpu_ready stayed 0 for %0d cycles, required 1", n);
    end
    acc = cyc;
    @(posedge iCLK);
    #1;
    if (hold) cpu_we = 1'b0;
    else      cpu_req = 1'b0;
    done = -1;
    n = 0;
    while (n < 200) begin
      @(negedge iCLK);
      if (cpu_err || (we ? cpu_wdone : cpu_rvalid)) begin
        done = cyc;
        break;
      end
      n++;
    end
    if (done < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no completion pulse within %0d cycles, required one", n);
    end
  endtask

  int acc, done, acc2, done2;
  int w0, r0, v0, d0, e0;

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    avl_waitrequest = 0; avl_readdatavalid = 0; avl_readdata = '0; rd_line = '0;
    for (int i = 0; i < 1024; i++) rmem[i] = 8'(i * 7 + 3);
    for (int l = 0; l < 64; l++)
      for (int k = 0; k < 16; k++) smem[l][k*8 +: 8] = 8'((l * 16 + k) * 7 + 3);

    fork
      slave_loop();
      monitor_loop();
    join_none

    repeat (3) @(negedge iCLK);
    chk("reset_flags", {cpu_ready, cpu_wdone, cpu_rvalid, cpu_err, avl_read, avl_write}, 6'b100000);
    chk("reset_avl_bus", {avl_address, avl_byteenable, avl_writedata}, '0);
    chk("reset_rdata", cpu_rdata, 32'h0);
    @(posedge iCLK); #1 iRST_n = 1'b1;
    @(negedge iCLK);

    // Zero-wait write: line 1, word 2.
    w0 = n_wr_cyc; d0 = n_wdone;
    cpu_op(1, 32'h0000_0018, 32'hDEADBEEF, 4'hF, 0, acc, done);
    chk("t1_latency", done - acc, 2);
    chk("t1_wr_cycles", n_wr_cyc - w0, 1);
    chk("t1_addr", last_wr_addr, 26'h1);
    chk("t1_be", last_wr_be, 16'h0F00);
    chk("t1_wdone_count", n_wdone - d0, 1);

    // Read with 3 wait states and readdatavalid 4 cycles after acceptance.
    preload_word(32'h0000_0024, 32'h12345678);
    wait_n = 3; rdv_delay = 4;
    r0 = n_rd_cyc; v0 = n_rvalid;
    cpu_op(0, 32'h0000_0024, '0, '0, 0, acc, done);
    chk("t2_latency", done - acc, 9);
    chk("t2_rd_cycles", n_rd_cyc - r0, 4);
    chk("t2_addr", last_rd_addr, 26'h2);
    chk("t2_rdata", cpu_rdata, 32'h12345678);
    chk("t2_rvalid_count", n_rvalid - v0, 1);

    // Misaligned read.
    wait_n = 0; rdv_delay = 1;
    r0 = n_rd_cyc; w0 = n_wr_cyc; e0 = n_err;
    cpu_op(0, 32'h0000_0002, '0, '0, 0, acc, done);
    chk("t3_err_latency", done - acc, 1);
    repeat (4) @(negedge iCLK);
    chk("t3_err_count", n_err - e0, 1);
    chk("t3_no_avl_activity", (n_rd_cyc - r0) + (n_wr_cyc - w0), 0);
    chk("t3_ready_after_err", cpu_ready, 1'b1);

    // Byte-enable patterns across one line, with and without wait states.
    cpu_op(1, 32'h0000_0080, 32'h11223344, 4'hF, 0, acc, done);
    wait_n = 2;
    w0 = n_wr_cyc;
    cpu_op(1, 32'h0000_0084, 32'h55667788, 4'h3, 0, acc, done);
    chk("t4_wait_latency", done - acc, 4);
    chk("t4_wr_cycles", n_wr_cyc - w0, 3);
    wait_n = 0;
    cpu_op(1, 32'h0000_0088, 32'hFFFFFFFF, 4'h0, 0, acc, done);
    chk("t4_zero_be", last_wr_be, 16'h0000);
    cpu_op(1, 32'h0000_008C, 32'h99AABBCC, 4'hC, 0, acc, done);
    chk("t4_be_hi", last_wr_be, 16'hC000);
    rdv_delay = 2;
    cpu_op(0, 32'h0000_0080, '0, '0, 0, acc, done);
    chk("t4_read_latency", done - acc, 4);
    cpu_op(0, 32'h0000_0084, '0, '0, 0, acc, done);
    cpu_op(0, 32'h0000_008C, '0, '0, 0, acc, done);
    cpu_op(0, 32'h0000_0088, '0, '0, 0, acc, done);
    chk("t4_untouched_word", cpu_rdata, 32'hD0C9C2BB);

    // Back-to-back write then read of the same address with cpu_req held.
    rdv_delay = 1;
    cpu_op(1, 32'h0000_0030, 32'hCAFEF00D, 4'hF, 1, acc, done);
    chk("t5_rdata_held", cpu_rdata, 32'hD0C9C2BB);
    cpu_op(0, 32'h0000_0030, '0, '0, 0, acc2, done2);
    chk("t5_read_after_wdone", acc2 - done, 0);
    chk("t5_read_accept_cycle", acc2 - acc, 2);
    chk("t5_rdata", cpu_rdata, 32'hCAFEF00D);

    // Reset while waiting for read data; the late readdatavalid must be ignored.
    rdv_delay = 8;
    exp_rd_line = 26'h5;
    exp_err = 0;
    cpu_we = 0; cpu_addr = 32'h0000_0050; cpu_req = 1'b1;
    while (!cpu_ready) @(negedge iCLK);
    @(posedge iCLK); #1 cpu_req = 1'b0;
    repeat (2) @(negedge iCLK);
    v0 = n_rvalid;
    #1 iRST_n = 1'b0;
    #1;
    chk("t6_reset_flags", {cpu_ready, cpu_wdone, cpu_rvalid, cpu_err, avl_read, avl_write}, 6'b100000);
    @(posedge iCLK); #1 iRST_n = 1'b1;
    repeat (12) @(negedge iCLK);
    chk("t6_no_rvalid", n_rvalid - v0, 0);
    chk("t6_ready", cpu_ready, 1'b1);
    rdv_delay = 1;
    cpu_op(0, 32'h0000_0050, '0, '0, 0, acc, done);
    chk("t6_recovery_latency", done - acc, 3);

`ifdef AVL_BRIDGE_LINE_BUF_EN
    r0 = n_rd_cyc;
    cpu_op(0, 32'h0000_0040, '0, '0, 0, acc, done);
    chk("lb_miss_latency", done - acc, 3);
    chk("lb_miss_rd_cycles", n_rd_cyc - r0, 1);
    r0 = n_rd_cyc;
    cpu_op(0, 32'h0000_0040, '0, '0, 0, acc, done);
    chk("lb_hit_latency", done - acc, 2);
    chk("lb_hit_no_avl", n_rd_cyc - r0, 0);
    cpu_op(1, 32'h0000_0044, 32'hAAAA5555, 4'h3, 0, acc, done);
    r0 = n_rd_cyc;
    cpu_op(0, 32'h0000_0044, '0, '0, 0, acc, done);
    chk("lb_merge_no_avl", n_rd_cyc - r0, 0);
    chk("lb_merge_latency", done - acc, 2);
    chk("lb_merge_rdata", cpu_rdata, 32'hF4ED5555);
`endif

    repeat (3) @(negedge iCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avl_word_bridge.md
Name: avl_word_bridge

Overview:
Parametrised CPU-to-Avalon-MM master bridge for the DDR path.
- Accepts word-sized, byte-enabled CPU requests on a byte address.
- Translates each request into a single line-wide Avalon transaction, with byteenable generation and lane steering.
- Holds read/write until waitrequest drops and returns explicit completion pulses to the CPU.
- Sits between the CPU load/store stage and the SDRAM controller Avalon port.

Parameters:
- AVL_ADDR_W, 26, Avalon line-address width.
- AVL_DATA_W, 128, Avalon data width; power of 2, ≥ CPU_DATA_W.
- CPU_ADDR_W, 32, CPU byte-address width; must be ≥ AVL_ADDR_W+log2(AVL_DATA_W/8).
- CPU_DATA_W, 32, CPU word width; power of 2, ≥ 8.

Ports:
- iCLK  in  1  clock.
- iRST_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  CPU_ADDR_W  byte address.
- cpu_wdata  in  CPU_DATA_W  write word.
- cpu_be  in  CPU_DATA_W/8  byte enables within the word.
- cpu_ready  out  1  bridge can accept; high only in IDLE.
- cpu_wdone  out  1  one-cycle pulse: write accepted by Avalon.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  CPU_DATA_W  read word, registered.
- cpu_err  out  1  one-cycle pulse: misaligned request rejected.
- avl_waitrequest  in  1  slave stall.
- avl_readdatavalid  in  1  read data valid.
- avl_readdata  in  AVL_DATA_W  read line.
- avl_address  out  AVL_ADDR_W  line address.
- avl_read  out  1  read strobe.
- avl_write  out  1  write strobe.
- avl_writedata  out  AVL_DATA_W  write line.
- avl_byteenable  out  AVL_DATA_W/8  byte enables.

Behaviour:
- Reset (async, iRST_n low):
  - All outputs are 0 except cpu_ready = 1.
  - FSM goes to IDLE; line buffer (if present) is invalidated.
- Derived constants:
  - LB = log2(AVL_DATA_W/8), WB = log2(CPU_DATA_W/8).
  - Line address = cpu_addr[LB +: AVL_ADDR_W]; higher address bits are ignored.
  - Word index = cpu_addr[LB-1:WB].
- Accept: cpu_req && cpu_ready. cpu_addr, cpu_we, cpu_wdata and cpu_be are registered on accept.
- Misalign: cpu_addr[WB-1:0] != 0 on accept.
  - cpu_err pulses the next cycle.
  - No Avalon activity; the FSM stays in IDLE.
- Write lane steering:
  - avl_writedata = cpu_wdata replicated across all words.
  - avl_byteenable = cpu_be shifted to word index; all other bits 0.
  - cpu_be = 0 is legal and issues a write with zero byteenables.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, RESP.
  - IDLE → WR (write accepted) or RD_REQ (read accepted); avl_address is loaded on the same edge.
  - WR: avl_write = 1 held, address/data/byteenable stable, until a cycle with avl_waitrequest = 0. On that edge: avl_write ← 0, cpu_wdone pulses next cycle, → IDLE.
  - RD_REQ: avl_read = 1 held until avl_waitrequest = 0. On that edge: avl_read ← 0, → RD_WAIT.
  - RD_WAIT: on avl_readdatavalid, cpu_rdata ← selected word of avl_readdata, → RESP.
  - RESP: cpu_rvalid = 1 for one cycle, → IDLE.
  - cpu_ready is high in IDLE only.
- Latency with zero wait states:
  - Write: accept at cycle 0 → avl_write at 1 → cpu_wdone at 2.
  - Read: accept at 0 → avl_read at 1 → readdatavalid at ≥2 → cpu_rvalid one cycle after readdatavalid.
- Only one transaction is outstanding; there is no pipelining.
- avl_readdatavalid outside RD_WAIT is ignored.
- cpu_req held high while not ready: no effect; the request must be re-presented when cpu_ready = 1.
- cpu_rdata holds its value until the next read completes.
- Reset mid-transaction: strobes drop immediately, the transaction is abandoned and no completion pulse is produced.

Optional Feature:
- Macro: AVL_BRIDGE_LINE_BUF_EN.
- Defined: a one-entry line buffer holds the last read line, its line address and a valid bit.
  - Read hit in IDLE: no Avalon transaction; cpu_rvalid pulses 2 cycles after accept via RESP.
  - Read miss: normal read; the returned line fills the buffer.
  - Write to the buffered line: buffer bytes are updated per byteenable (write-through); Avalon write is still issued.
- Undefined: every read goes to Avalon; no buffer storage is synthesised.

Decomposition:
- Package avl_bridge_pkg:
  - FSM state encoding (IDLE = 0, WR = 1, RD_REQ = 2, RD_WAIT = 3, RESP = 4; 3 bits).
  - Default width constants.
  - clog2 helper function.
- Sub-module avl_line_buf (only instantiated under AVL_BRIDGE_LINE_BUF_EN):
  - Storage, hit compare, byte-masked update, invalidate on reset.

Test Plan:
- Write addr 0x0000_0018, wdata 0xDEADBEEF, be 0xF, waitrequest low → avl_address 0x1, byteenable 0x0F00, avl_write one cycle, cpu_wdone at cycle 2.
- Read addr 0x0000_0024; waitrequest high 3 cycles, readdatavalid 4 cycles later with word1 = 0x12345678 → avl_read held 4 cycles with stable address 0x2; cpu_rdata 0x12345678 with one cpu_rvalid.
- Read addr 0x0000_0002 → cpu_err pulse; no avl_read/avl_write ever asserted.
- Assert iRST_n low while in RD_WAIT → strobes 0, cpu_ready 1, no cpu_rvalid; subsequent stray readdatavalid ignored.
- Back-to-back write then read to the same address with cpu_req held high → read accepted only after cpu_wdone; rdata equals written value from memory model.
- With AVL_BRIDGE_LINE_BUF_EN: two reads of 0x40, second causes no avl_read and cpu_rvalid 2 cycles after accept; write 0x44 be 0x3 then read 0x44 returns merged value.
